pulse_width_meter: RTL and testbench
====================================

Name: pulse_width_meter

Overview:
Receive-side counterpart to the one-shot pulse generator. It samples a single-bit pulse line, measures each high period in clk cycles, and classifies the result against an expected width. Each result is delivered on a valid/ready result port. It sits downstream of one_shot or token-bucket grant outputs as a checker and telemetry source.

Parameters:
CNT_W, 8, width of the measurement counter; maximum reportable width is 2^CNT_W-1
MIN_WIDTH, 1, pulses shorter than this (in cycles) are glitches: discarded, not reported, not counted
EXP_WIDTH, 6, expected pulse width; drives meas_match

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
pulse_in  in  1  pulse line, synchronous to clk
clear  in  1  sync clear of overrun and pulse_count
meas_valid  out  1  result available
meas_ready  in  1  consumer accepts result
meas_width  out  CNT_W  measured high width in cycles
meas_sat  out  1  width saturated at 2^CNT_W-1
meas_match  out  1  meas_width == EXP_WIDTH and not saturated
overrun  out  1  sticky: a completed measurement was dropped
pulse_count  out  16  number of results loaded into the output register, wraps at 2^16

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values: all outputs 0; state IDLE; counter 0.
- The internal pulse_q register resets to 1, so a line already high at reset release is ignored until it has been seen low.
- Width definition: number of posedges at which pulse_in is sampled 1 within one high period. A one_shot with PULSE_LEN=6 yields width 6.
- FSM IDLE:
  - Rising edge (pulse_in=1, pulse_q=0) -> MEASURE with cnt=1.
- FSM MEASURE:
  - pulse_in=1 -> cnt+1, saturating at 2^CNT_W-1; sat flag set on reaching the max.
  - pulse_in=0 -> completion; -> IDLE.
- Back-to-back pulses: a single low cycle between pulses is legal; the next rising edge is accepted the cycle after completion.
- Completion:
  - cnt < MIN_WIDTH -> discard silently.
  - Otherwise the result is offered to the output register at the completing posedge. meas_valid is visible from that edge, i.e. 1 cycle after the last high sample.
- Output register:
  - Loads when meas_valid=0, or when meas_valid & meas_ready in the same cycle as a completion. In the latter case meas_valid stays 1 and the new data replaces the old.
  - Handshake: meas_valid & meas_ready with no completion pending -> meas_valid=0 next cycle.
  - meas_width, meas_sat and meas_match stay stable while meas_valid=1 and ready=0.
  - Completion while meas_valid=1 and meas_ready=0 -> new result dropped, old result held, overrun<=1, pulse_count not incremented.
- pulse_count increments on every load into the output register.
- clear:
  - Zeroes overrun and pulse_count next cycle; does not touch the FSM, counter or output register.
  - clear with a simultaneous load: pulse_count=1 (the load wins over the clear). clear with a simultaneous overrun event: overrun=1.
- Saturation: on completion with the sat flag set, meas_width=2^CNT_W-1, meas_sat=1, meas_match=0.
- Reset mid-pulse: the measurement is aborted; because pulse_q=1 after reset, that pulse is never reported.

Decomposition:
- Shared package/include pulse_pkg:
  - FSM state encodings S_IDLE, S_MEASURE.
  - Saturation constant CNT_MAX = 2^CNT_W-1.
- Natural sub-module edge_detect: registered previous-value flop with a reset-value parameter, producing rise and fall. It can be reused by the token-bucket front end.
- The FSM/counter and the output register plus handshake stay in pulse_width_meter.

Test Plan:
- one_shot (PULSE_LEN=6) output fed in, meas_ready=1:
  - meas_valid high exactly 1 cycle, 1 cycle after the last high sample.
  - meas_width=6, meas_match=1, pulse_count=1.
- Pulses of 3 and 5 cycles separated by 1 low cycle, ready=1 -> two results, widths 3 then 5, match=0, pulse_count=2.
- MIN_WIDTH=2, 1-cycle glitch followed by a 4-cycle pulse -> only width 4 reported, pulse_count=1.
- meas_ready=0, three 2-cycle pulses:
  - First result (width 2) is held; overrun=1 after the second completion; pulse_count=1.
  - Raise ready with a 1-cycle clear -> valid drops, overrun=0, pulse_count=0.
- CNT_W=4, pulse held 20 cycles -> meas_width=15, meas_sat=1, meas_match=0.
- pulse_in high across reset release and for 3 more cycles, then a 6-cycle pulse -> only the width-6 result appears. Separately, reset asserted mid-pulse -> no result from that pulse.

Source files
------------

// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared state encoding and saturation helper for pulse_width_meter
package pulse_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  // CNT_MAX for a counter of width w: 2^w - 1
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/pulse_width_meter_edge_detect.sv
// rtl/pulse_width_meter_edge_detect.sv - registered previous-value flop producing rise/fall strobes
module edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= RESET_VAL;
    else        r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures high periods of a pulse line and reports them on a valid/ready port
module pulse_width_meter
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_WIDTH = 1,
  parameter int unsigned EXP_WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             clear,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_width,
  output logic             meas_sat,
  output logic             meas_match,
  output logic             overrun,
  output logic [15:0]      pulse_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_valid;
  logic [CNT_W-1:0] r_width;
  logic             r_msat;
  logic             r_match;
  logic             r_overrun;
  logic [15:0]      r_count;

  logic w_rise;
  logic w_fall;
  logic w_done;
  logic w_keep;
  logic w_load;
  logic w_drop;

  // Resets high so a line already asserted at reset release is not a rising edge.
  edge_detect #(.RESET_VAL(1'b1)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pulse_in),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  assign w_done = (r_state == S_MEASURE) && w_fall;
  assign w_keep = w_done && (32'(r_cnt) >= MIN_WIDTH);
  assign w_load = w_keep && (!r_valid || meas_ready);
  assign w_drop = w_keep && r_valid && !meas_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_MEASURE;
            r_cnt   <= CNT_ONE;
            r_sat   <= (CNT_ONE == CNT_MAX);
          end
        end
        S_MEASURE: begin
          if (pulse_in) begin
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_ONE;
              if (r_cnt == CNT_MAX - CNT_ONE) r_sat <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_width   <= '0;
      r_msat    <= 1'b0;
      r_match   <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_width <= r_cnt;
        r_msat  <= r_sat;
        r_match <= (32'(r_cnt) == EXP_WIDTH) && !r_sat;
      end else if (r_valid && meas_ready) begin
        r_valid <= 1'b0;
      end

      // A drop or a load in the same cycle as clear takes priority over it.
      if (w_drop)     r_overrun <= 1'b1;
      else if (clear) r_overrun <= 1'b0;

      if (w_load)     r_count <= clear ? 16'd1 : r_count + 16'd1;
      else if (clear) r_count <= '0;
    end
  end

  assign meas_valid  = r_valid;
  assign meas_width  = r_width;
  assign meas_sat    = r_msat;
  assign meas_match  = r_match;
  assign overrun     = r_overrun;
  assign pulse_count = r_count;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - directed self-checking bench for pulse_width_meter
module tb_pulse_width_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pulse_in;
  logic        clear;
  logic        meas_ready;

  logic        a_valid, a_sat, a_match, a_ovr;
  logic [7:0]  a_width;
  logic [15:0] a_cnt;
  logic        b_valid, b_sat, b_match, b_ovr;
  logic [7:0]  b_width;
  logic [15:0] b_cnt;
  logic        c_valid, c_sat, c_match, c_ovr;
  logic [3:0]  c_width;
  logic [15:0] c_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_width_meter dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear),
    .meas_valid(a_valid), .meas_ready(meas_ready), .meas_width(a_width),
    .meas_sat(a_sat), .meas_match(a_match), .overrun(a_ovr), .pulse_count(a_cnt)
  );

  pulse_width_meter #(.MIN_WIDTH(2)) dut_min (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear),
    .meas_valid(b_valid), .meas_ready(meas_ready), .meas_width(b_width),
    .meas_sat(b_sat), .meas_match(b_match), .overrun(b_ovr), .pulse_count(b_cnt)
  );

  pulse_width_meter #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear),
    .meas_valid(c_valid), .meas_ready(meas_ready), .meas_width(c_width),
    .meas_sat(c_sat), .meas_match(c_match), .overrun(c_ovr), .pulse_count(c_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic p);
    pulse_in = p;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    pulse_in = 1'b0;
    clear = 1'b0;
    meas_ready = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", a_valid, 0);
    check("rst_width", a_width, 0);
    check("rst_overrun", a_ovr, 0);
    check("rst_count", a_cnt, 0);
    check("rst_sat", c_sat, 0);

    // One-shot style 6-cycle pulse
    step(0);
    for (int i = 0; i < 6; i++) step(1);
    check("os_not_early", a_valid, 0);
    step(0);
    check("os_valid", a_valid, 1);
    check("os_width", a_width, 6);
    check("os_match", a_match, 1);
    check("os_sat", a_sat, 0);
    check("os_count", a_cnt, 1);
    step(0);
    check("os_valid_one_cycle", a_valid, 0);

    // Back-to-back 3 and 5 with one low cycle
    do_reset();
    step(0);
    for (int i = 0; i < 3; i++) step(1);
    step(0);
    check("b2b_valid0", a_valid, 1);
    check("b2b_width0", a_width, 3);
    check("b2b_match0", a_match, 0);
    step(1);
    check("b2b_handshake", a_valid, 0);
    for (int i = 0; i < 4; i++) step(1);
    step(0);
    check("b2b_valid1", a_valid, 1);
    check("b2b_width1", a_width, 5);
    check("b2b_match1", a_match, 0);
    check("b2b_count", a_cnt, 2);

    // Glitch below MIN_WIDTH=2 then 4-cycle pulse
    do_reset();
    step(0);
    step(1);
    step(0);
    check("glitch_dropped", b_valid, 0);
    check("glitch_count", b_cnt, 0);
    for (int i = 0; i < 4; i++) step(1);
    step(0);
    check("min_valid", b_valid, 1);
    check("min_width", b_width, 4);
    check("min_count", b_cnt, 1);

    // ready=0, three 2-cycle pulses, then ready+clear
    do_reset();
    meas_ready = 1'b0;
    step(0);
    step(1); step(1); step(0);
    check("hold_valid", a_valid, 1);
    check("hold_width", a_width, 2);
    check("hold_ovr0", a_ovr, 0);
    step(1); step(1); step(0);
    check("ovr_set", a_ovr, 1);
    check("ovr_width_held", a_width, 2);
    check("ovr_count", a_cnt, 1);
    step(1); step(1); step(0);
    check("ovr_valid_held", a_valid, 1);
    check("ovr_count2", a_cnt, 1);
    meas_ready = 1'b1;
    clear = 1'b1;
    step(0);
    clear = 1'b0;
    check("clr_valid", a_valid, 0);
    check("clr_ovr", a_ovr, 0);
    check("clr_count", a_cnt, 0);

    // clear coinciding with a load, then with an overrun event
    do_reset();
    step(0);
    step(1);
    clear = 1'b1;
    step(0);
    clear = 1'b0;
    check("clr_load_count", a_cnt, 1);
    check("clr_load_valid", a_valid, 1);
    meas_ready = 1'b0;
    step(1);
    clear = 1'b1;
    step(0);
    clear = 1'b0;
    check("clr_ovr_wins", a_ovr, 1);
    check("clr_ovr_count", a_cnt, 0);
    meas_ready = 1'b1;

    // 20-cycle pulse: saturates at CNT_W=4
    do_reset();
    step(0);
    for (int i = 0; i < 20; i++) step(1);
    step(0);
    check("sat_valid", c_valid, 1);
    check("sat_width", c_width, 15);
    check("sat_flag", c_sat, 1);
    check("sat_match", c_match, 0);
    check("wide_width", a_width, 20);
    check("wide_sat", a_sat, 0);

    // Line high across reset release is ignored
    pulse_in = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) step(1);
    step(0);
    check("rel_ignored", a_valid, 0);
    check("rel_count0", a_cnt, 0);
    for (int i = 0; i < 6; i++) step(1);
    step(0);
    check("rel_width", a_width, 6);
    check("rel_count", a_cnt, 1);

    // Reset asserted mid-pulse
    step(0);
    for (int i = 0; i < 3; i++) step(1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    step(1);
    step(1);
    step(0);
    check("midrst_valid", a_valid, 0);
    step(0);
    check("midrst_valid2", a_valid, 0);
    check("midrst_count", a_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
